// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter with rotating priority and a per-ownership hold
// limit, so a requester that keeps asking cannot starve the others.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_CAP = (MAX_HOLD > 0) ? HW'(MAX_HOLD) : '1;
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, ptr_nxt;
  logic [HW-1:0]   hold_cnt, hold_nxt;
  logic [ID_W-1:0] id_nxt;
  logic            valid_nxt;
  logic [N-1:0]    gnt_nxt;
  logic            owner_req;
  logic            others_req;
  logic [ID_W-1:0] ptr_after;
  logic [ID_W:0]   win_ptr;
  logic [ID_W:0]   win_after;

  // Winner is the requester at the smallest rotational distance from the pointer;
  // the MSB of the result flags that some request was found.
  function automatic logic [ID_W:0] pick(input logic [N-1:0] r, input logic [ID_W-1:0] p);
    logic [ID_W:0] res;
    int            best_d;
    int            d;
    res    = '0;
    best_d = N;
    for (int i = 0; i < N; i++) begin
      d = (i - int'(p) + N) % N;
      if (r[i] && d < best_d) begin
        best_d = d;
        res    = {1'b1, ID_W'(i)};
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= id_nxt;
      gnt_valid <= valid_nxt;
    end
  end

  always_comb begin
    owner_req  = |(req & gnt);
    others_req = |(req & ~gnt);
    ptr_after  = ID_W'((int'(gnt_id) + 1) % N);
    win_ptr    = pick(req, ptr);
    win_after  = pick(req, ptr_after);
    state_nxt  = state;
    ptr_nxt    = ptr;
    hold_nxt   = hold_cnt;
    id_nxt     = gnt_id;
    valid_nxt  = gnt_valid;
    case (state)
      IDLE: begin
        if (win_ptr[ID_W]) begin
          state_nxt = OWN;
          id_nxt    = win_ptr[ID_W-1:0];
          valid_nxt = 1'b1;
          hold_nxt  = HOLD_ONE;
        end else begin
          id_nxt    = '0;
          valid_nxt = 1'b0;
        end
      end
      OWN: begin
        // Release and preemption both advance the pointer past the owner and hand
        // over on the same edge, so there is no idle bubble between owners.
        if (!owner_req || (MAX_HOLD != 0 && hold_cnt == HOLD_CAP && others_req)) begin
          ptr_nxt = ptr_after;
          if (win_after[ID_W]) begin
            id_nxt    = win_after[ID_W-1:0];
            valid_nxt = 1'b1;
            hold_nxt  = HOLD_ONE;
          end else begin
            state_nxt = IDLE;
            id_nxt    = '0;
            valid_nxt = 1'b0;
            hold_nxt  = '0;
          end
        end else if (hold_cnt != HOLD_CAP) begin
          hold_nxt = hold_cnt + HOLD_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        id_nxt    = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    gnt_nxt = '0;
    if (valid_nxt) gnt_nxt[id_nxt] = 1'b1;
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed, table-driven bench for rr_arbiter with N=4 and MAX_HOLD=4.
module tb_rr_arbiter;

  localparam int N = 4;
  localparam int M = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         gnt_valid;

  int tests;
  int fails;

  typedef struct {
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] exp_gnt;
  } vec_t;

  vec_t vecs[$];

  rr_arbiter #(.N(N), .MAX_HOLD(M)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic add_vec(input logic r, input logic [N-1:0] q, input logic [N-1:0] g);
    vec_t v;
    v.rst_n   = r;
    v.req     = q;
    v.exp_gnt = g;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
  task automatic applyStimulus(input logic r, input logic [N-1:0] q);
    @(negedge clk);
    rst_n = r;
    req   = q;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [N-1:0] exp_gnt);
    logic [1:0] exp_id;
    logic       exp_valid;
    exp_id    = '0;
    exp_valid = |exp_gnt;
    for (int i = 0; i < N; i++)
      if (exp_gnt[i]) exp_id = 2'(i);
    tests++;
    if (gnt !== exp_gnt || gnt_id !== exp_id || gnt_valid !== exp_valid) begin
      fails++;
      $display("[TB] FAIL %s: got gnt=%b id=%0d valid=%b, want gnt=%b id=%0d valid=%b",
               tag, gnt, gnt_id, gnt_valid, exp_gnt, exp_id, exp_valid);
    end
  endtask

  initial begin
    int waited;
    bit seen;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req   = '0;

    // Reset held with full requests, then full contention rotation.
    for (int i = 0; i < 3; i++) add_vec(1'b0, 4'b1111, 4'b0000);
    for (int i = 0; i < 4; i++) add_vec(1'b1, 4'b1111, 4'b0001);
    for (int i = 0; i < 4; i++) add_vec(1'b1, 4'b1111, 4'b0010);
    for (int i = 0; i < 4; i++) add_vec(1'b1, 4'b1111, 4'b0100);
    for (int i = 0; i < 4; i++) add_vec(1'b1, 4'b1111, 4'b1000);
    for (int i = 0; i < 4; i++) add_vec(1'b1, 4'b1111, 4'b0001);

    // Release handoff without a bubble, then idle.
    add_vec(1'b0, 4'b0011, 4'b0000);
    add_vec(1'b1, 4'b0011, 4'b0001);
    add_vec(1'b1, 4'b0011, 4'b0001);
    add_vec(1'b1, 4'b0010, 4'b0010);
    add_vec(1'b1, 4'b0000, 4'b0000);

    // Sole requester far past the hold limit, then a newcomer preempts.
    add_vec(1'b0, 4'b0000, 4'b0000);
    for (int i = 0; i < 20; i++) add_vec(1'b1, 4'b0100, 4'b0100);
    add_vec(1'b1, 4'b0101, 4'b0001);

    // Wrap-around: owner 2 releases, pointer 3 picks 3 before 0.
    add_vec(1'b0, 4'b0000, 4'b0000);
    add_vec(1'b1, 4'b0100, 4'b0100);
    add_vec(1'b1, 4'b1001, 4'b1000);
    add_vec(1'b1, 4'b0001, 4'b0001);
    add_vec(1'b1, 4'b0000, 4'b0000);

    // Mid-ownership reset must also return the pointer (left at 2) to 0.
    add_vec(1'b0, 4'b0000, 4'b0000);
    add_vec(1'b1, 4'b0010, 4'b0010);
    add_vec(1'b1, 4'b0000, 4'b0000);
    add_vec(1'b1, 4'b0010, 4'b0010);
    add_vec(1'b0, 4'b1110, 4'b0000);
    add_vec(1'b1, 4'b1110, 4'b0010);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].req);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_gnt);
    end

    // Worst-case wait: requester 3 under full contention gets its grant on edge (N-1)*M+1.
    applyStimulus(1'b0, 4'b0000);
    checkOutput("wait_reset", 4'b0000);
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < (N - 1) * M + 4) begin
      applyStimulus(1'b1, 4'b1111);
      waited++;
      if (gnt[3]) seen = 1'b1;
    end
    tests++;
    if (!seen || waited != (N - 1) * M + 1) begin
      fails++;
      $display("[TB] FAIL worst_wait: got %0d edges (granted=%0d), want %0d",
               waited, seen, (N - 1) * M + 1);
    end

    // Preemption on a non-owner pulse: owner 3 at its limit loses to requester 0.
    for (int i = 0; i < M - 1; i++) applyStimulus(1'b1, 4'b1000);
    checkOutput("sole3_hold", 4'b1000);
    applyStimulus(1'b1, 4'b1001);
    checkOutput("preempt3", 4'b0001);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("final_idle", 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
